// File: rtl/truth_table_sweeper_pkg.sv
// Shared types and sizes for the truth-table sweeper.
// Optional comparator enabled by defining TRUTH_SWEEP_COMPARE_EN.
package truth_sweep_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    SAMPLE,
    DONE
  } state_t;

  localparam int VEC_COUNT = 8;
  localparam int IDX_W     = 3;
  localparam int TABLE_W   = 16;
  localparam int CNT_W     = 8;

  // Lowest 2-bit slot where the two tables differ; 0 when they are equal.
  function automatic logic [IDX_W-1:0] lowest_mismatch(input logic [TABLE_W-1:0] got,
                                                       input logic [TABLE_W-1:0] gold);
    logic [IDX_W-1:0] res;
    res = '0;
    for (int i = VEC_COUNT - 1; i >= 0; i--) begin
      if (got[2*i +: 2] != gold[2*i +: 2]) res = IDX_W'(i);
    end
    return res;
  endfunction

endpackage

// File: rtl/truth_table_sweeper_settle_counter.sv
// Down-counter that times how long each vector is held before sampling.
module settle_counter
  import truth_sweep_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             en,
  output logic             expired
);

  logic [CNT_W-1:0] cnt;

  // Load on settle entry, then count down and park at zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (en && cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign expired = (cnt == '0);

endmodule

// File: rtl/truth_table_sweeper.sv
// Exhaustive 3-input stimulus / 2-output capture stage.
// Define TRUTH_SWEEP_COMPARE_EN to check the captured table against EXPECTED_TABLE.
//
// state  | meaning
// IDLE   | waiting for start; a,b,c and table_out hold
// SETTLE | current vector held while the unit settles
// SAMPLE | {x,y} captured into slot idx, then advance or finish
// DONE   | publish done pulse and compare result
module truth_table_sweeper
  import truth_sweep_pkg::*;
#(
  parameter int                 SETTLE_CYCLES  = 2,
  parameter logic [TABLE_W-1:0] EXPECTED_TABLE = 16'h0000
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  output logic               a,
  output logic               b,
  output logic               c,
  input  logic               x,
  input  logic               y,
  output logic               busy,
  output logic               done,
  output logic [TABLE_W-1:0] table_out,
  output logic               pass,
  output logic [IDX_W-1:0]   err_idx
);

  if (SETTLE_CYCLES < 1 || SETTLE_CYCLES > 255) begin : g_bad_settle
    $error("SETTLE_CYCLES must be within 1..255");
  end
  if ($bits(EXPECTED_TABLE) != TABLE_W) begin : g_bad_table
    $error("EXPECTED_TABLE width mismatch");
  end

  state_t           state;
  logic [IDX_W-1:0] idx;
  logic [IDX_W-1:0] vec;
  logic             accept;
  logic             cnt_load;
  logic             expired;
  logic             cmp_pass;
  logic [IDX_W-1:0] cmp_err;

  // A start in the cycle done is still high is deliberately dropped.
  assign accept   = (state == IDLE) && start && !done;
  assign cnt_load = accept || (state == SAMPLE && idx != IDX_W'(VEC_COUNT - 1));

  settle_counter u_settle (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (cnt_load),
    .load_val (CNT_W'(SETTLE_CYCLES - 1)),
    .en       (state == SETTLE),
    .expired  (expired)
  );

`ifdef TRUTH_SWEEP_COMPARE_EN
  // Golden compare of the finished table; lowest differing index reported.
  always_comb begin
    cmp_pass = (table_out == EXPECTED_TABLE);
    cmp_err  = lowest_mismatch(table_out, EXPECTED_TABLE);
  end
`else
  assign cmp_pass = 1'b0;
  assign cmp_err  = '0;
`endif

  // Sweep sequencer, vector register and table capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      idx       <= '0;
      vec       <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      table_out <= '0;
      pass      <= 1'b0;
      err_idx   <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            state     <= SETTLE;
            idx       <= '0;
            vec       <= '0;
            busy      <= 1'b1;
            table_out <= '0;
            pass      <= 1'b0;
            err_idx   <= '0;
          end
        end
        SETTLE: begin
          if (expired) state <= SAMPLE;
        end
        SAMPLE: begin
          table_out[{idx, 1'b0} +: 2] <= {x, y};
          if (idx == IDX_W'(VEC_COUNT - 1)) begin
            state <= DONE;
          end else begin
            idx   <= idx + 1'b1;
            vec   <= idx + 1'b1;
            state <= SETTLE;
          end
        end
        DONE: begin
          done    <= 1'b1;
          busy    <= 1'b0;
          pass    <= cmp_pass;
          err_idx <= cmp_err;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign a = vec[2];
  assign b = vec[1];
  assign c = vec[0];

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Self-checking bench for truth_table_sweeper.
module tb_truth_table_sweeper;

  logic clk = 1'b0;
  logic rst_n;
  logic start0, start3;
  logic mode;
  logic [15:0] rand_tbl;
  int cur_sel;
  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  logic a0, b0, c0, x0, y0, busy0, done0, pass0;
  logic a1, b1, c1, x1, y1, busy1, done1, pass1;
  logic a2, b2, c2, x2, y2, busy2, done2, pass2;
  logic a3, b3, c3, x3, y3, busy3, done3, pass3;
  logic [15:0] tbl0, tbl1, tbl2, tbl3;
  logic [2:0]  err0, err1, err2, err3;

  truth_table_sweeper #(.SETTLE_CYCLES(2), .EXPECTED_TABLE(16'hB414)) d0 (
    .clk(clk), .rst_n(rst_n), .start(start0), .a(a0), .b(b0), .c(c0), .x(x0), .y(y0),
    .busy(busy0), .done(done0), .table_out(tbl0), .pass(pass0), .err_idx(err0));
  truth_table_sweeper #(.SETTLE_CYCLES(2), .EXPECTED_TABLE(16'hB415)) d1 (
    .clk(clk), .rst_n(rst_n), .start(start0), .a(a1), .b(b1), .c(c1), .x(x1), .y(y1),
    .busy(busy1), .done(done1), .table_out(tbl1), .pass(pass1), .err_idx(err1));
  truth_table_sweeper #(.SETTLE_CYCLES(2), .EXPECTED_TABLE(16'hF414)) d2 (
    .clk(clk), .rst_n(rst_n), .start(start0), .a(a2), .b(b2), .c(c2), .x(x2), .y(y2),
    .busy(busy2), .done(done2), .table_out(tbl2), .pass(pass2), .err_idx(err2));
  truth_table_sweeper #(.SETTLE_CYCLES(1), .EXPECTED_TABLE(16'h0000)) d3 (
    .clk(clk), .rst_n(rst_n), .start(start3), .a(a3), .b(b3), .c(c3), .x(x3), .y(y3),
    .busy(busy3), .done(done3), .table_out(tbl3), .pass(pass3), .err_idx(err3));

  // Units under test: reference logic, or a random lookup table for d0.
  logic [2:0] i0;
  logic [1:0] xy0;
  always_comb begin
    i0  = {a0, b0, c0};
    xy0 = mode ? rand_tbl[2*i0 +: 2] : {a0 & b0, b0 ^ c0};
    x0  = xy0[1];
    y0  = xy0[0];
    x1  = a1 & b1;  y1 = b1 ^ c1;
    x2  = a2 & b2;  y2 = b2 ^ c2;
    x3  = 1'b1;     y3 = 1'b0;
  end

  logic [2:0]  o_abc, o_err;
  logic        o_busy, o_done, o_pass;
  logic [15:0] o_tbl;
  always_comb begin
    if (cur_sel == 3) begin
      o_abc = {a3, b3, c3}; o_busy = busy3; o_done = done3;
      o_tbl = tbl3; o_pass = pass3; o_err = err3;
    end else begin
      o_abc = {a0, b0, c0}; o_busy = busy0; o_done = done0;
      o_tbl = tbl0; o_pass = pass0; o_err = err0;
    end
  end

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Table produced by the reference unit x=a&b, y=b^c.
  function automatic logic [15:0] ref_table();
    logic [15:0] t;
    t = '0;
    for (int i = 0; i < 8; i++) begin
      t[2*i+1] = ((i >> 2) & 1) & ((i >> 1) & 1);
      t[2*i]   = ((i >> 1) & 1) ^ (i & 1);
    end
    return t;
  endfunction

  function automatic logic exp_pass(input logic [15:0] t, input logic [15:0] g);
`ifdef TRUTH_SWEEP_COMPARE_EN
    return t == g;
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [2:0] exp_err(input logic [15:0] t, input logic [15:0] g);
`ifdef TRUTH_SWEEP_COMPARE_EN
    for (int i = 0; i < 8; i++)
      if (t[2*i +: 2] != g[2*i +: 2]) return 3'(i);
`endif
    return 3'd0;
  endfunction

  task automatic set_start(input int sel, input logic v);
    if (sel == 3) start3 = v; else start0 = v;
  endtask

  // Called at a negedge; start is raised immediately and sampled on the next edge.
  task automatic sweep(input int sel, input int s, input logic [15:0] tbl,
                       input logic [15:0] gold, input bit restart, input bit peers,
                       input bit reset_mid);
    int done_m;
    int ei;
    done_m = 8 * (s + 1) + 1;
    cur_sel = sel;
    set_start(sel, 1'b1);
    @(negedge clk);
    set_start(sel, 1'b0);
    for (int m = 0; m <= done_m + 1; m++) begin
      if (reset_mid && m == 10) begin
        rst_n = 1'b0;
        #1;
        chk("rst_abc",  16'(o_abc),  16'd0);
        chk("rst_busy", 16'(o_busy), 16'd0);
        chk("rst_done", 16'(o_done), 16'd0);
        chk("rst_tbl",  o_tbl,       16'd0);
        chk("rst_pass", 16'(o_pass), 16'd0);
        chk("rst_err",  16'(o_err),  16'd0);
        @(negedge clk);
        rst_n = 1'b1;
        return;
      end
      ei = m / (s + 1);
      if (ei > 7) ei = 7;
      chk("abc",  16'(o_abc),  16'(ei));
      chk("busy", 16'(o_busy), 16'(m < done_m));
      chk("done", 16'(o_done), 16'(m == done_m));
      if (m == 0) chk("tbl_clear", o_tbl, 16'd0);
      if (m == done_m) begin
        chk("table", o_tbl, tbl);
        chk("pass",  16'(o_pass), 16'(exp_pass(tbl, gold)));
        chk("err",   16'(o_err),  16'(exp_err(tbl, gold)));
        if (peers) begin
          chk("d1_pass", 16'(pass1), 16'(exp_pass(tbl, 16'hB415)));
          chk("d1_err",  16'(err1),  16'(exp_err(tbl, 16'hB415)));
          chk("d2_pass", 16'(pass2), 16'(exp_pass(tbl, 16'hF414)));
          chk("d2_err",  16'(err2),  16'(exp_err(tbl, 16'hF414)));
        end
      end
      set_start(sel, restart && (m == 5 || m == done_m));
      @(negedge clk);
    end
    set_start(sel, 1'b0);
    chk("hold_table", o_tbl, tbl);
  endtask

  initial begin
    rst_n = 1'b0; start0 = 1'b0; start3 = 1'b0; mode = 1'b0; rand_tbl = '0; cur_sel = 0;
    repeat (2) @(negedge clk);
    chk("reset_abc",  16'({a0, b0, c0}), 16'd0);
    chk("reset_busy", 16'(busy0), 16'd0);
    chk("reset_done", 16'(done0), 16'd0);
    chk("reset_tbl",  tbl0, 16'd0);
    chk("reset_pass", 16'(pass0), 16'd0);
    chk("reset_err",  16'(err0), 16'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Reference unit with a mid-sweep start and a start on the done cycle.
    sweep(0, 2, ref_table(), 16'hB414, 1'b1, 1'b1, 1'b0);
    // Start the cycle after done, then abort with reset.
    sweep(0, 2, ref_table(), 16'hB414, 1'b0, 1'b0, 1'b1);
    for (int n = 0; n < 30; n++) begin
      chk("idle_busy", 16'(busy0), 16'd0);
      chk("idle_done", 16'(done0), 16'd0);
      @(negedge clk);
    end

    // Randomly generated units.
    mode = 1'b1;
    for (int r = 0; r < 4; r++) begin
      rand_tbl = 16'($urandom);
      sweep(0, 2, rand_tbl, 16'hB414, 1'b0, 1'b0, 1'b0);
      repeat (2) @(negedge clk);
    end
    mode = 1'b0;

    // Constant unit, shortest settle.
    sweep(3, 1, 16'hAAAA, 16'h0000, 1'b0, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
